// File: rtl/uart_tx_arbiter_if.sv
//------------------------------------------------------------------------------
// uart_tx_arbiter_if : requester byte streams and UART transmitter handshake
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  // Requesters and the transmitter sit on the master side, the arbiter on the slave side.
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// uart_tx_arbiter : message-locked round-robin sharing of one UART transmitter
// Optional stall timeout: define UART_ARB_TIMEOUT_EN.       Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int OWNER_W      = 2,
  parameter int IDLE_TIMEOUT = 2400000
) (
  input  wire logic               clk,
  input  wire logic               reset,
  uart_tx_arbiter_if.slave        bus,
  output logic [OWNER_W-1:0]      owner,
  output logic                    owner_valid,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (2**OWNER_W) < NUM_REQ || IDLE_TIMEOUT < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: invalid parameter set");
  end

  state_t               r_state;
  logic [OWNER_W-1:0]   r_ptr;
  logic [OWNER_W-1:0]   r_owner;
  logic                 r_owner_valid;
  logic                 r_last;
  logic                 r_tx_valid;
  logic [7:0]           r_tx_data;
  logic [NUM_REQ-1:0]   r_req_ready;

  logic                 w_hit;
  logic [OWNER_W-1:0]   w_pick;
  logic                 w_own_valid;
  logic                 w_own_last;
  logic [7:0]           w_own_data;
  logic [OWNER_W-1:0]   w_ptr_next;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_idle_expired;

  // Walk offsets from the far end so the smallest offset from the pointer wins.
  always_comb begin
    w_hit  = 1'b0;
    w_pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == (int'(r_ptr) + i) % NUM_REQ && bus.req_valid[j]) begin
          w_hit  = 1'b1;
          w_pick = OWNER_W'(j);
        end
      end
    end
  end

  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (r_owner == OWNER_W'(j)) begin
        w_own_valid = bus.req_valid[j];
        w_own_last  = bus.req_last[j];
        w_own_data  = bus.req_data[8*j +: 8];
      end
    end
  end

  assign w_ptr_next = (r_owner == OWNER_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_grant    = NUM_REQ'(1) << r_owner;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(IDLE_TIMEOUT);

  logic [CNT_W-1:0] r_idle_cnt;

  assign w_idle_expired = (r_state == ST_FETCH) && !w_own_valid &&
                          (r_idle_cnt == CNT_W'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || r_state != ST_FETCH || w_own_valid || w_idle_expired) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  assign w_idle_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_ARB;
      r_ptr         <= '0;
      r_owner       <= '0;
      r_owner_valid <= 1'b0;
      r_last        <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= '0;
      r_req_ready   <= '0;
    end else begin
      r_req_ready <= '0;
      case (r_state)
        ST_ARB: begin
          if (w_hit) begin
            r_owner       <= w_pick;
            r_owner_valid <= 1'b1;
            r_state       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (w_own_valid) begin
            r_tx_data   <= w_own_data;
            r_last      <= w_own_last;
            r_req_ready <= w_grant;
            r_state     <= ST_SEND;
          end else if (w_idle_expired) begin
            r_owner_valid <= 1'b0;
            r_ptr         <= w_ptr_next;
            r_state       <= ST_ARB;
          end
        end
        ST_SEND: begin
          if (bus.tx_ready && !r_tx_valid) begin
            r_tx_valid <= 1'b1;
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // The transmitter dropping ready means it has taken the byte.
          if (r_tx_valid && !bus.tx_ready) begin
            r_tx_valid <= 1'b0;
            if (r_last) begin
              r_owner_valid <= 1'b0;
              r_ptr         <= w_ptr_next;
              r_state       <= ST_ARB;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign bus.tx_data   = r_tx_data;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.req_ready = r_req_ready;
  assign owner         = r_owner;
  assign owner_valid   = r_owner_valid;
  assign busy          = (r_state != ST_ARB);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// tb_uart_tx_arbiter : scoreboard bench for uart_tx_arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 3;
  localparam int OWNER_W      = 2;
  localparam int IDLE_TIMEOUT = 16;

  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic [OWNER_W-1:0] owner;
  logic               owner_valid;
  logic               busy;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .OWNER_W     (OWNER_W),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .owner      (owner),
    .owner_valid(owner_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OWNER_W-1:0] src;
    logic [7:0]         data;
  } exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } byte_t;

  exp_t  exp_q[$];
  byte_t rq0[$];
  byte_t rq1[$];
  byte_t rq2[$];

  int checks = 0;
  int errors = 0;
  int rdy_cnt[NUM_REQ];
  bit force_low = 1'b0;
  int cooldown  = 0;
  logic prev_tx_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_tx(input int src, input logic [7:0] d);
    exp_t e;
    e.src  = OWNER_W'(src);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_req(input int r, input logic [7:0] d, input logic l);
    byte_t b;
    b.data = d;
    b.last = l;
    case (r)
      0:       rq0.push_back(b);
      1:       rq1.push_back(b);
      default: rq2.push_back(b);
    endcase
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || rq0.size() != 0 || rq1.size() != 0 ||
            rq2.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain: actual %0d pending bytes, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_ready_pulse(input int r, input int base, input string name);
    int n = 0;
    while (rdy_cnt[r] <= base && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s_ready_wait: actual %0d pulses, required > %0d", name, rdy_cnt[r], base);
    end
  endtask

  task automatic wait_tx_valid(input logic lvl, input string name);
    int n = 0;
    while (bus.tx_valid !== lvl && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s_tx_valid_wait: actual %0b required %0b", name, bus.tx_valid, lvl);
    end
  endtask

  // Requester model: present queue heads, pop on the consume pulse.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      if (bus.req_ready[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (bus.req_ready[1] && rq1.size() > 0) void'(rq1.pop_front());
      if (bus.req_ready[2] && rq2.size() > 0) void'(rq2.pop_front());
      bus.req_valid[0]     = (rq0.size() > 0);
      bus.req_valid[1]     = (rq1.size() > 0);
      bus.req_valid[2]     = (rq2.size() > 0);
      bus.req_data[7:0]    = (rq0.size() > 0) ? rq0[0].data : 8'h00;
      bus.req_data[15:8]   = (rq1.size() > 0) ? rq1[0].data : 8'h00;
      bus.req_data[23:16]  = (rq2.size() > 0) ? rq2[0].data : 8'h00;
      bus.req_last[0]      = (rq0.size() > 0) ? rq0[0].last : 1'b0;
      bus.req_last[1]      = (rq1.size() > 0) ? rq1[0].last : 1'b0;
      bus.req_last[2]      = (rq2.size() > 0) ? rq2[0].last : 1'b0;
    end
  end

  // Transmitter model: takes a byte one cycle after valid, then busy for 10 cycles.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (force_low) begin
        bus.tx_ready = 1'b0;
      end else if (bus.tx_valid && bus.tx_ready) begin
        bus.tx_ready = 1'b0;
        cooldown     = 10;
      end else if (cooldown > 0) begin
        cooldown--;
        bus.tx_ready = (cooldown == 0);
      end else begin
        bus.tx_ready = 1'b1;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [NUM_REQ-1:0] one;
    exp_t e;
    one = 1;
    forever begin
      @(negedge clk);
      if (bus.tx_valid && !prev_tx_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: actual src %0d data %02h, required no byte", owner, bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          if (owner !== e.src || bus.tx_data !== e.data) begin
            errors++;
            $display("FAIL tx_byte: actual src %0d data %02h, required src %0d data %02h",
                     owner, bus.tx_data, e.src, e.data);
          end
        end
      end
      if (bus.req_ready != '0) begin
        checks++;
        if (bus.req_ready !== (one << owner) || owner_valid !== 1'b1) begin
          errors++;
          $display("FAIL req_ready_owner: actual ready %03b owner %0d lock %0b, required owner bit only",
                   bus.req_ready, owner, owner_valid);
        end
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) rdy_cnt[i]++;
      end
      prev_tx_valid = bus.tx_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base0;
    int base1;
    int n;
    for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_valid",    32'(bus.tx_valid),  32'h0);
    check("reset_owner_valid", 32'(owner_valid),   32'h0);
    check("reset_busy",        32'(busy),          32'h0);
    check("reset_req_ready",   32'(bus.req_ready), 32'h0);
    check("reset_tx_data",     32'(bus.tx_data),   32'h0);
    check("reset_owner",       32'(owner),         32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single requester, four-byte ANSI sequence
    base0 = rdy_cnt[0];
    expect_tx(0, 8'h1B); expect_tx(0, 8'h5B); expect_tx(0, 8'h3B); expect_tx(0, 8'h48);
    push_req(0, 8'h1B, 1'b0); push_req(0, 8'h5B, 1'b0);
    push_req(0, 8'h3B, 1'b0); push_req(0, 8'h48, 1'b1);
    wait_drain("single");
    check("single_owner_valid", 32'(owner_valid), 32'h0);
    check("single_ready_count", 32'(rdy_cnt[0] - base0), 32'd4);

    // Pointer now 1: simultaneous 0 and 1 must grant 1 first
    expect_tx(1, 8'hA1); expect_tx(0, 8'hA0);
    push_req(1, 8'hA1, 1'b1); push_req(0, 8'hA0, 1'b1);
    wait_drain("pointer");

    // Lock hold: req 0 arrives during req 1's message
    base0 = rdy_cnt[0];
    base1 = rdy_cnt[1];
    expect_tx(1, 8'h11); expect_tx(1, 8'h12); expect_tx(1, 8'h13); expect_tx(0, 8'h20);
    push_req(1, 8'h11, 1'b0); push_req(1, 8'h12, 1'b0); push_req(1, 8'h13, 1'b1);
    wait_ready_pulse(1, base1, "lock");
    push_req(0, 8'h20, 1'b1);
    wait_drain("lock");
    check("lock_ready1_count", 32'(rdy_cnt[1] - base1), 32'd3);
    check("lock_ready0_count", 32'(rdy_cnt[0] - base0), 32'd1);

    // Reset while the first byte of a message is in HOLD
    repeat (15) @(negedge clk);
    expect_tx(2, 8'h77);
    push_req(2, 8'h77, 1'b0); push_req(2, 8'h78, 1'b1);
    wait_tx_valid(1'b1, "rst_mid");
    reset = 1'b1;
    rq0.delete(); rq1.delete(); rq2.delete();
    @(negedge clk);
    check("rst_mid_tx_valid",    32'(bus.tx_valid),  32'h0);
    check("rst_mid_owner_valid", 32'(owner_valid),   32'h0);
    check("rst_mid_busy",        32'(busy),          32'h0);
    check("rst_mid_req_ready",   32'(bus.req_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (15) @(negedge clk);

    // Round robin with continuous single-byte messages from all three
    for (int k = 0; k < 3; k++) begin
      expect_tx(0, 8'h30); expect_tx(1, 8'h31); expect_tx(2, 8'h32);
      push_req(0, 8'h30, 1'b1); push_req(1, 8'h31, 1'b1); push_req(2, 8'h32, 1'b1);
    end
    wait_drain("round_robin");

    // Backpressure in SEND
    repeat (15) @(negedge clk);
    force_low = 1'b1;
    @(negedge clk);
    base0 = rdy_cnt[0];
    expect_tx(0, 8'h55);
    push_req(0, 8'h55, 1'b1);
    wait_ready_pulse(0, base0, "bp");
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("bp_tx_valid_low", 32'(bus.tx_valid), 32'h0);
      check("bp_tx_data_hold", 32'(bus.tx_data),  32'h55);
    end
    force_low = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!bus.tx_ready && n < 10);
    #1;
    check("bp_tx_valid_rise", 32'(bus.tx_valid), 32'h1);
    wait_drain("bp");

`ifdef UART_ARB_TIMEOUT_EN
    // Stalled owner loses its lock after IDLE_TIMEOUT cycles in FETCH
    repeat (15) @(negedge clk);
    expect_tx(2, 8'h40); expect_tx(0, 8'h41);
    push_req(2, 8'h40, 1'b0);
    wait_tx_valid(1'b1, "timeout");
    push_req(0, 8'h41, 1'b1);
    wait_tx_valid(1'b0, "timeout");
    n = 0;
    while (owner_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd16);
    wait_drain("timeout");
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (valid/ready byte interface, 115200 baud) among several byte-stream requesters, e.g. board dump, ANSI home sequence and welcome/status ROM strings.
- Arbitration is round-robin at message granularity: once a requester is granted, it keeps the transmitter until it presents a byte flagged last.
- The block owns the transmitter handshake (valid asserted while ready is high, dropped once ready falls), so requesters only provide bytes.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- OWNER_W, 2, width of the owner index; must satisfy 2**OWNER_W >= NUM_REQ.
- IDLE_TIMEOUT, 2400000, clock cycles a locked owner may stall (no req_valid) before the lock is revoked; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  requester i has a byte on its data slice
- req_data  in  NUM_REQ*8  byte of requester i on bits [8i+7:8i]
- req_last  in  NUM_REQ  byte of requester i ends its message
- req_ready  out  NUM_REQ  one-cycle pulse: byte of requester i consumed
- tx_data  out  8  byte to the UART transmitter
- tx_valid  out  1  transmit request to the UART transmitter
- tx_ready  in  1  transmitter idle/ready
- owner  out  OWNER_W  index of the current grant holder
- owner_valid  out  1  a message lock is held
- busy  out  1  state machine is not in ARB

Behaviour:
- Reset: all outputs are 0; state ARB; round-robin pointer 0; timeout counter 0. Reset mid-byte drops tx_valid on the next edge, and any partial message is abandoned.
- ARB:
  - Scan req_valid starting at the pointer, wrapping modulo NUM_REQ.
  - On the first hit k: owner<=k, owner_valid<=1, go to FETCH.
  - No requests: stay in ARB.
- FETCH:
  - If req_valid[owner]: latch req_data slice into tx_data, latch req_last into last_r, pulse req_ready[owner] for exactly 1 cycle, go to SEND.
  - Otherwise wait in FETCH.
- SEND: when tx_ready=1 and tx_valid=0, set tx_valid<=1 and go to HOLD.
- HOLD:
  - Stay while tx_ready=1.
  - On tx_valid=1 and tx_ready=0: tx_valid<=0.
  - If last_r: owner_valid<=0, pointer<=(owner+1) mod NUM_REQ, go to ARB.
  - Else: go to FETCH with the same owner.
- Latency: a request in ARB gives the req_ready pulse 2 cycles later (ARB, then FETCH edge). tx_valid rises 1 cycle after FETCH if tx_ready is already high.
- Ownership rules:
  - Only the owner's req_ready may pulse; the other req_ready bits stay 0.
  - Non-owner req_valid is ignored while owner_valid=1.
- Simultaneous requests: the lowest index at or after the pointer wins; after a message completes the pointer advances, which guarantees fairness.
- Single-byte message (valid and last together): one byte, then return to ARB.
- Pointer wrap: owner NUM_REQ-1 completes, pointer becomes 0.
- tx_data is held stable from FETCH until the HOLD exit.
- busy = (state != ARB).

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - In FETCH with req_valid[owner]=0, a counter increments every cycle.
  - On reaching IDLE_TIMEOUT-1: owner_valid<=0, pointer<=owner+1, go to ARB.
  - The counter clears on leaving FETCH.
- Not defined: no counter is synthesized; a stalled owner holds the lock indefinitely.

Test Plan:
- Single requester:
  - Stimulus: req 0 sends 0x1B,0x5B,0x3B,0x48, last on 0x48; transmitter model drops ready 1 cycle after valid and holds it low for 10 cycles.
  - Required: 4 tx_valid pulses with those bytes in order, 4 req_ready[0] pulses, then owner_valid=0 and pointer=1.
- Lock hold:
  - Stimulus: req 1 sends a 3-byte message; req 0 asserts valid during byte 2.
  - Required: all 3 bytes of req 1 go out before any byte of req 0; req_ready[0] stays 0 until the lock is released.
- Round-robin:
  - Stimulus: reqs 0, 1, 2 all request continuously with 1-byte messages 0x30, 0x31, 0x32.
  - Required: tx byte sequence 0x30, 0x31, 0x32, 0x30, ...; pointer wraps 2->0.
- Backpressure:
  - Stimulus: tx_ready held 0 for 50 cycles while in SEND.
  - Required: tx_valid stays 0 and tx_data stays stable; tx_valid rises 1 cycle after tx_ready=1.
- Reset mid-message:
  - Stimulus: reset asserted while in HOLD.
  - Required: next cycle tx_valid=0, owner_valid=0, busy=0, req_ready=0.
- Timeout (UART_ARB_TIMEOUT_EN, IDLE_TIMEOUT=16):
  - Stimulus: req 2 sends 1 non-last byte, then drops valid while req 0 is requesting.
  - Required: owner_valid falls 16 cycles into FETCH and req 0 is granted next.
